// File: rtl/ddram_arbiter_if.sv
// Purpose: one DDRAM-style port: command/write-beat request side plus read return side.
// Latency: wires only, no storage.
// Backpressure: BUSY from the slave side stalls RD/WE; masters hold ADDR/DIN/BE/BURSTCNT while BUSY=1.
// Ports: ADDR, DIN, BE, BURSTCNT, RD, WE travel master->slave; BUSY, DOUT, DOUT_READY travel slave->master.
interface ddram_arbiter_if #(
   parameter int ADDRBITS = 24
);
   logic [ADDRBITS:0] ADDR;
   logic [63:0]       DIN;
   logic [7:0]        BE;
   logic [7:0]        BURSTCNT;
   logic              RD;
   logic              WE;
   logic              BUSY;
   logic [63:0]       DOUT;
   logic              DOUT_READY;

   modport master (
      output ADDR, DIN, BE, BURSTCNT, RD, WE,
      input  BUSY, DOUT, DOUT_READY
   );

   modport slave (
      input  ADDR, DIN, BE, BURSTCNT, RD, WE,
      output BUSY, DOUT, DOUT_READY
   );
endinterface

// File: rtl/ddram_arbiter.sv
// Purpose: two-master (m0 = L2 cache, m1 = video scanout/DMA) to one-slave DDR3 arbiter, whole-burst grants.
// Latency: 1 cycle arbitration before the command reaches DDR; read return path is combinational (0 cycles).
// Backpressure: owner sees DDRAM_BUSY on its BUSY during GRANT/WDATA; every other cycle both BUSY are held at 1.
// Ports: CLK, RESET_N (synchronous, active low); m0, m1 = slave modports facing the masters;
//        ddram = master modport facing the DDR controller.
// Option: define DDRAM_ARB_RR_EN for round-robin on ties; default is fixed priority, m1 over m0.
module ddram_arbiter #(
   parameter int ADDRBITS = 24,
   parameter int MAXBURST = 128
) (
   input  logic             CLK,
   input  logic             RESET_N,
   ddram_arbiter_if.slave   m0,
   ddram_arbiter_if.slave   m1,
   ddram_arbiter_if.master  ddram
);

   typedef enum logic [1:0] {IDLE, GRANT, WDATA, RDATA} state_t;

   state_t            state, state_nxt;
   logic              owner, owner_nxt;
   logic [7:0]        beats_left, beats_nxt;

   logic [ADDRBITS:0] own_addr;
   logic [63:0]       own_din;
   logic [7:0]        own_be;
   logic [7:0]        own_bc;
   logic [7:0]        own_bc_clamped;
   logic              own_rd, own_we;
   logic              own_busy, own_dready;
   logic              m0_req, m1_req, any_req, winner;

   // BURSTCNT of 0 means a single beat; oversize bursts are limited to MAXBURST.
   function automatic logic [7:0] clamp_bc(input logic [7:0] bc);
      if (bc == 8'd0)
         return 8'd1;
      if (int'(bc) > MAXBURST)
         return 8'(MAXBURST);
      return bc;
   endfunction

   assign m0_req  = m0.RD | m0.WE;
   assign m1_req  = m1.RD | m1.WE;
   assign any_req = m0_req | m1_req;

`ifdef DDRAM_ARB_RR_EN
   // Holds the most recent grant; a tie goes to the other master.
   logic last_owner;

   assign winner = (m0_req && m1_req) ? ~last_owner : m1_req;

   always_ff @(posedge CLK) begin
      if (!RESET_N)
         last_owner <= 1'b1;
      else if (state == IDLE && any_req)
         last_owner <= winner;
   end
`else
   assign winner = m1_req;
`endif

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state      <= IDLE;
         owner      <= 1'b0;
         beats_left <= 8'd0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         beats_left <= beats_nxt;
      end
   end

   always_comb begin
      own_addr       = owner ? m1.ADDR     : m0.ADDR;
      own_din        = owner ? m1.DIN      : m0.DIN;
      own_be         = owner ? m1.BE       : m0.BE;
      own_bc         = owner ? m1.BURSTCNT : m0.BURSTCNT;
      own_rd         = owner ? m1.RD       : m0.RD;
      own_we         = owner ? m1.WE       : m0.WE;
      own_bc_clamped = clamp_bc(own_bc);

      ddram.ADDR     = own_addr;
      ddram.DIN      = own_din;
      ddram.BE       = own_be;
      ddram.BURSTCNT = own_bc;
      ddram.RD       = 1'b0;
      ddram.WE       = 1'b0;
      own_busy       = 1'b1;
      own_dready     = 1'b0;
      state_nxt      = state;
      owner_nxt      = owner;
      beats_nxt      = beats_left;

      case (state)
         IDLE: begin
            if (any_req) begin
               owner_nxt = winner;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            // A simultaneous RD and WE issues the read; the write waits for a later grant.
            ddram.RD = own_rd;
            ddram.WE = own_we & ~own_rd;
            own_busy = ddram.BUSY;
            if (own_rd && !ddram.BUSY) begin
               beats_nxt = own_bc_clamped;
               state_nxt = RDATA;
            end else if (own_we && !ddram.BUSY) begin
               beats_nxt = own_bc_clamped - 8'd1;
               state_nxt = (own_bc_clamped == 8'd1) ? IDLE : WDATA;
            end
         end
         WDATA: begin
            ddram.WE = own_we;
            own_busy = ddram.BUSY;
            if (own_we && !ddram.BUSY) begin
               if (beats_left != 8'd0)
                  beats_nxt = beats_left - 8'd1;
               if (beats_left <= 8'd1)
                  state_nxt = IDLE;
            end
         end
         RDATA: begin
            own_dready = ddram.DOUT_READY;
            if (ddram.DOUT_READY) begin
               if (beats_left != 8'd0)
                  beats_nxt = beats_left - 8'd1;
               if (beats_left <= 8'd1)
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // While reset is held nothing may be issued or returned, whatever the state register holds.
      if (!RESET_N) begin
         ddram.RD   = 1'b0;
         ddram.WE   = 1'b0;
         own_busy   = 1'b1;
         own_dready = 1'b0;
      end

      m0.BUSY       = owner ? 1'b1 : own_busy;
      m1.BUSY       = owner ? own_busy : 1'b1;
      m0.DOUT_READY = ~owner & own_dready;
      m1.DOUT_READY = owner & own_dready;
      m0.DOUT       = ddram.DOUT;
      m1.DOUT       = ddram.DOUT;
   end

endmodule

// File: tb/tb_ddram_arbiter.sv
module tb_ddram_arbiter;
   localparam int ADDRBITS = 24;
   localparam int MAXBURST = 128;

   logic CLK = 1'b0;
   logic RESET_N;
   always #5 CLK = ~CLK;

   ddram_arbiter_if #(.ADDRBITS(ADDRBITS)) m0_if ();
   ddram_arbiter_if #(.ADDRBITS(ADDRBITS)) m1_if ();
   ddram_arbiter_if #(.ADDRBITS(ADDRBITS)) dd_if ();

   ddram_arbiter #(.ADDRBITS(ADDRBITS), .MAXBURST(MAXBURST)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .m0      (m0_if),
      .m1      (m1_if),
      .ddram   (dd_if)
   );

   // master-side stimulus, indexed by master number
   logic [ADDRBITS:0] m_addr [2];
   logic [63:0]       m_din  [2];
   logic [7:0]        m_be   [2];
   logic [7:0]        m_bc   [2];
   logic [1:0]        m_rd, m_we;
   logic [1:0]        m_busy, m_dready;
   logic [63:0]       m_dout [2];

   assign m0_if.ADDR = m_addr[0];  assign m1_if.ADDR = m_addr[1];
   assign m0_if.DIN  = m_din[0];   assign m1_if.DIN  = m_din[1];
   assign m0_if.BE   = m_be[0];    assign m1_if.BE   = m_be[1];
   assign m0_if.BURSTCNT = m_bc[0]; assign m1_if.BURSTCNT = m_bc[1];
   assign m0_if.RD   = m_rd[0];    assign m1_if.RD   = m_rd[1];
   assign m0_if.WE   = m_we[0];    assign m1_if.WE   = m_we[1];
   assign m_busy   = {m1_if.BUSY, m0_if.BUSY};
   assign m_dready = {m1_if.DOUT_READY, m0_if.DOUT_READY};
   assign m_dout[0] = m0_if.DOUT;
   assign m_dout[1] = m1_if.DOUT;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Reference rule for burst length.
   function automatic int beats_of(input int bc);
      if (bc == 0) return 1;
      if (bc > MAXBURST) return MAXBURST;
      return bc;
   endfunction

   task automatic idle_inputs();
      m_rd = 2'b00;
      m_we = 2'b00;
      dd_if.BUSY = 1'b0;
      dd_if.DOUT_READY = 1'b0;
      dd_if.DOUT = 64'd0;
   endtask

   task automatic reset_dut();
      RESET_N = 1'b0;
      idle_inputs();
      @(negedge CLK);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);
   endtask

   // Waits (bounded) for a master to see BUSY=0; returns its index.
   task automatic wait_grant(input string tag, output int who);
      who = -1;
      for (int c = 0; c < 20 && who < 0; c++) begin
         #1;
         if (!m_busy[0]) who = 0;
         else if (!m_busy[1]) who = 1;
         if (who < 0) @(negedge CLK);
      end
      if (who < 0) begin
         chk({tag, "_timeout"}, 64'd1, 64'd0);
         who = 0;
      end
   endtask

   // Delivers n read beats from the DDR side and checks they reach only master 'who'.
   task automatic serve_read(input string tag, input int who, input int n);
      logic [63:0] d;
      for (int b = 0; b < n; b++) begin
         d = {$urandom, $urandom};
         dd_if.DOUT = d;
         dd_if.DOUT_READY = 1'b1;
         #1;
         chk({tag, "_rdy"}, m_dready[who], 1);
         chk({tag, "_other"}, m_dready[1-who], 0);
         chk({tag, "_dat"}, m_dout[who], d);
         @(negedge CLK);
      end
      dd_if.DOUT_READY = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int who, first_exp;
      logic [63:0] d;

      for (int i = 0; i < 2; i++) begin
         m_addr[i] = '0; m_din[i] = '0; m_be[i] = 8'hFF; m_bc[i] = 8'd1;
      end
      RESET_N = 1'b0;
      idle_inputs();
      @(negedge CLK);

      // ---- reset state, with requests present to show they are ignored
      m_rd = 2'b11;
      #1;
      chk("rst_busy", m_busy, 2'b11);
      chk("rst_dready", m_dready, 2'b00);
      chk("rst_ddram_rd", dd_if.RD, 0);
      chk("rst_ddram_we", dd_if.WE, 0);
      chk("rst_state", dut.state, 0);
      chk("rst_beats", dut.beats_left, 0);
      reset_dut();

      // ---- read from M0, 8 beats
      m_addr[0] = 25'h100; m_bc[0] = 8'd8; m_rd[0] = 1'b1;
      #1;
      chk("rd_idle_busy", m_busy[0], 1);
      chk("rd_idle_ddram_rd", dd_if.RD, 0);
      @(negedge CLK); #1;
      chk("rd_grant_ddram_rd", dd_if.RD, 1);
      chk("rd_grant_addr", dd_if.ADDR, 64'h100);
      chk("rd_grant_bc", dd_if.BURSTCNT, 8);
      chk("rd_grant_m0_busy", m_busy[0], 0);
      chk("rd_grant_m1_busy", m_busy[1], 1);
      @(negedge CLK);
      m_rd[0] = 1'b0;
      #1;
      chk("rd_rdata_busy", m_busy, 2'b11);
      serve_read("rd_beat", 0, 8);
      #1;
      chk("rd_end_state", dut.state, 0);
      chk("rd_end_busy", m_busy, 2'b11);

      // ---- single write from M0 with DDR stalled 3 cycles
      @(negedge CLK);
      m_addr[0] = 25'h200; m_bc[0] = 8'd1; m_be[0] = 8'h0F;
      m_din[0] = 64'hDEAD_BEEF_0123_4567; m_we[0] = 1'b1; dd_if.BUSY = 1'b1;
      #1;
      chk("wr_idle_we", dd_if.WE, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK); #1;
         chk("wr_stall_we", dd_if.WE, 1);
         chk("wr_stall_be", dd_if.BE, 8'h0F);
         chk("wr_stall_din", dd_if.DIN, 64'hDEAD_BEEF_0123_4567);
         chk("wr_stall_busy", m_busy[0], 1);
      end
      @(negedge CLK);
      dd_if.BUSY = 1'b0;
      #1;
      chk("wr_accept_busy", m_busy[0], 0);
      chk("wr_accept_we", dd_if.WE, 1);
      @(negedge CLK);
      m_we[0] = 1'b0;
      #1;
      chk("wr_end_state", dut.state, 0);
      chk("wr_end_we", dd_if.WE, 0);

      // ---- simultaneous reads, twice, from a fresh reset
`ifdef DDRAM_ARB_RR_EN
      first_exp = 0;
`else
      first_exp = 1;
`endif
      reset_dut();
      for (int r = 0; r < 2; r++) begin
         m_addr[0] = 25'h300; m_addr[1] = 25'h400; m_bc[0] = 8'd4; m_bc[1] = 8'd4;
         m_rd = 2'b11;
         wait_grant("tie_first", who);
         chk("tie_first_owner", who, first_exp);
         chk("tie_first_addr", dd_if.ADDR, (who == 1) ? 64'h400 : 64'h300);
         @(negedge CLK);
         m_rd[who] = 1'b0;
         serve_read("tie_a", who, 4);
         #1;
         chk("tie_gap_state", dut.state, 0);
         chk("tie_gap_busy", m_busy, 2'b11);
         @(negedge CLK); #1;
         chk("tie_second_busy", m_busy[1-who], 0);
         chk("tie_second_rd", dd_if.RD, 1);
         @(negedge CLK);
         m_rd[1-who] = 1'b0;
         serve_read("tie_b", 1 - who, 4);
      end

      // ---- stray beat in IDLE, then M1 4-beat write with a 2-cycle gap before beat 3
      reset_dut();
      dd_if.DOUT_READY = 1'b1;
      #1;
      chk("stray_idle_dready", m_dready, 2'b00);
      @(negedge CLK);
      dd_if.DOUT_READY = 1'b0;
      m_addr[1] = 25'h500; m_bc[1] = 8'd4; m_be[1] = 8'hA5;
      m_din[1] = {$urandom, $urandom}; m_we[1] = 1'b1;
      @(negedge CLK);
      for (int b = 0; b < 4; b++) begin
         #1;
         chk("wb_accept", m_busy[1], 0);
         chk("wb_we", dd_if.WE, 1);
         chk("wb_din", dd_if.DIN, m_din[1]);
         chk("wb_be", dd_if.BE, 8'hA5);
         @(negedge CLK);
         chk("wb_beats_left", dut.beats_left, 3 - b);
         if (b == 1) begin
            m_we[1] = 1'b0;
            dd_if.DOUT_READY = 1'b1;
            #1;
            chk("wb_stray_dready", m_dready, 2'b00);
            chk("wb_gap_we", dd_if.WE, 0);
            @(negedge CLK);
            dd_if.DOUT_READY = 1'b0;
            @(negedge CLK);
            chk("wb_gap_beats_left", dut.beats_left, 2);
         end
         if (b < 3) begin
            m_we[1] = 1'b1;
            m_din[1] = {$urandom, $urandom};
         end else begin
            m_we[1] = 1'b0;
         end
      end
      #1;
      chk("wb_end_state", dut.state, 0);

      // ---- reset after 3 of 8 read beats
      reset_dut();
      m_addr[0] = 25'h600; m_bc[0] = 8'd8; m_rd[0] = 1'b1;
      wait_grant("rr_grant", who);
      chk("rst_mid_owner", who, 0);
      @(negedge CLK);
      m_rd[0] = 1'b0;
      serve_read("rst_mid_beat", 0, 3);
      RESET_N = 1'b0;
      dd_if.DOUT = {$urandom, $urandom};
      dd_if.DOUT_READY = 1'b1;
      #1;
      chk("rst_mid_busy", m_busy, 2'b11);
      chk("rst_mid_dready", m_dready, 2'b00);
      @(negedge CLK);
      RESET_N = 1'b1;
      #1;
      chk("rst_mid_state", dut.state, 0);
      for (int b = 0; b < 4; b++) begin
         @(negedge CLK);
         dd_if.DOUT = {$urandom, $urandom};
         #1;
         chk("rst_late_dready", m_dready, 2'b00);
         chk("rst_late_busy", m_busy, 2'b11);
      end
      dd_if.DOUT_READY = 1'b0;

      // ---- randomized rounds against a transaction-level model
      reset_dut();
      begin
         int rr_last;
         int mask, exp_win, s_owner, s_left, cyc;
         int left_w [2];
         bit pending [2];
         bit started [2];
         bit drop [2];
         bit new_din [2];
         bit got_first, acc_rd;
         rr_last = 1;
         for (int r = 0; r < 60; r++) begin
            mask = $urandom_range(1, 3);
            for (int i = 0; i < 2; i++) begin
               pending[i] = mask[i];
               started[i] = 1'b0;
               drop[i] = 1'b0;
               new_din[i] = 1'b0;
               m_addr[i] = ADDRBITS'($urandom) << 1 | 25'(i);
               m_din[i] = {$urandom, $urandom};
               m_be[i] = 8'($urandom);
               case ($urandom_range(0, 9))
                  0:       m_bc[i] = 8'd0;
                  1:       m_bc[i] = 8'd200;
                  default: m_bc[i] = 8'($urandom_range(1, 6));
               endcase
               left_w[i] = beats_of(int'(m_bc[i]));
               acc_rd = $urandom_range(0, 1) == 1;
               m_rd[i] = mask[i] & acc_rd;
               m_we[i] = mask[i] & ~acc_rd;
            end
`ifdef DDRAM_ARB_RR_EN
            exp_win = (mask == 3) ? 1 - rr_last : ((mask == 2) ? 1 : 0);
`else
            exp_win = (mask == 1) ? 0 : 1;
`endif
            got_first = 1'b0;
            s_owner = 0;
            s_left = 0;
            cyc = 0;
            while ((pending[0] || pending[1] || s_left > 0) && cyc < 3000) begin
               for (int i = 0; i < 2; i++) begin
                  if (drop[i]) begin m_rd[i] = 1'b0; m_we[i] = 1'b0; drop[i] = 1'b0; end
                  if (new_din[i]) begin m_din[i] = {$urandom, $urandom}; new_din[i] = 1'b0; end
               end
               dd_if.BUSY = ($urandom_range(0, 3) == 0);
               d = {$urandom, $urandom};
               dd_if.DOUT = d;
               if (s_left > 0) dd_if.DOUT_READY = ($urandom_range(0, 2) != 0);
               else            dd_if.DOUT_READY = ($urandom_range(0, 7) == 0);
               #1;
               if (s_left > 0 && dd_if.DOUT_READY) begin
                  chk("rnd_rdy_owner", m_dready[s_owner], 1);
                  chk("rnd_rdy_other", m_dready[1-s_owner], 0);
                  chk("rnd_dat_owner", m_dout[s_owner], d);
                  chk("rnd_dat_other", m_dout[1-s_owner], d);
               end else begin
                  chk("rnd_no_rdy", m_dready, 2'b00);
               end
               if (s_left > 0) begin
                  chk("rnd_rdata_cmd", {dd_if.RD, dd_if.WE}, 2'b00);
               end
               chk("rnd_busy_excl", (m_busy == 2'b00), 0);
               if (dd_if.BUSY) chk("rnd_busy_stall", m_busy, 2'b11);
               for (int i = 0; i < 2; i++) begin
                  if (pending[i] && !m_busy[i]) begin
                     if (!got_first) begin
                        chk("rnd_winner", i, exp_win);
                        got_first = 1'b1;
                     end
                     if (!started[i]) begin
                        chk("rnd_addr", dd_if.ADDR, m_addr[i]);
                        chk("rnd_bc", dd_if.BURSTCNT, m_bc[i]);
                        started[i] = 1'b1;
                        rr_last = i;
                     end
                     if (m_rd[i]) begin
                        chk("rnd_rd_strobe", {dd_if.RD, dd_if.WE}, 2'b10);
                        s_owner = i;
                        s_left = beats_of(int'(dd_if.BURSTCNT)) + 1;
                        pending[i] = 1'b0;
                        drop[i] = 1'b1;
                     end else begin
                        chk("rnd_we_strobe", {dd_if.RD, dd_if.WE}, 2'b01);
                        chk("rnd_we_din", dd_if.DIN, m_din[i]);
                        chk("rnd_we_be", dd_if.BE, m_be[i]);
                        left_w[i]--;
                        if (left_w[i] == 0) begin
                           pending[i] = 1'b0;
                           drop[i] = 1'b1;
                        end else begin
                           new_din[i] = 1'b1;
                        end
                     end
                  end
               end
               // the +1 above cancels this cycle's decrement for a freshly accepted read
               if (s_left > 0 && (dd_if.DOUT_READY || drop[s_owner])) s_left--;
               @(negedge CLK);
               cyc++;
            end
            for (int i = 0; i < 2; i++) begin
               if (drop[i]) begin m_rd[i] = 1'b0; m_we[i] = 1'b0; drop[i] = 1'b0; end
            end
            dd_if.DOUT_READY = 1'b0;
            if (cyc >= 3000) begin
               chk("rnd_round_timeout", 64'd1, 64'd0);
               reset_dut();
               rr_last = 1;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
